data_island_scheduler: RTL and testbench

DATA_ISLAND_SCHEDULER -- requirements
Module: data_island_scheduler

---
 rtl/data_island_scheduler_if.sv | 22 ++
 rtl/data_island_scheduler.sv | 142 ++++++++++++++
 tb/tb_data_island_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/data_island_scheduler_if.sv
// data_island_scheduler_if: blanking/request inputs and packet-slot outputs of the data island scheduler.
interface data_island_scheduler_if;
    logic [11:0] blank_remaining;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  source_sel;
    logic        null_packet;
    logic        packet_start;
    logic        preamble;
    logic        guard;
    logic        data_island_period;

    modport master (
        output blank_remaining, req,
        input  grant, source_sel, null_packet, packet_start, preamble, guard, data_island_period
    );

    modport slave (
        input  blank_remaining, req,
        output grant, source_sel, null_packet, packet_start, preamble, guard, data_island_period
    );
endinterface

// File: rtl/data_island_scheduler.sv
// data_island_scheduler: schedules preamble/guard/packet slots of a data island with round-robin source arbitration.
// DATA_ISLAND_PRIORITY_SRC0_EN gives req[0] absolute priority over the round-robin among sources 1-3.
module data_island_scheduler #(
    parameter int MAX_PACKETS = 18,
    parameter int MIN_CONTROL = 12
) (
    input logic clk_pixel,
    input logic reset,
    data_island_scheduler_if.slave bus
);
    localparam int CW = (MIN_CONTROL > 32) ? $clog2(MIN_CONTROL) : 5;
    localparam int PW = $clog2(MAX_PACKETS + 1);
    localparam logic [12:0] ENTER_MIN = 13'(44 + MIN_CONTROL);
    localparam logic [12:0] CONT_MIN  = 13'(34 + MIN_CONTROL);

    typedef enum logic [2:0] {IDLE, PREAMBLE, GUARD_LEAD, PACKET, GUARD_TRAIL, COOLDOWN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] npk;
    logic [1:0]    ptr;
    logic [3:0]    cand;
    logic [3:0]    rr_set;
    logic [1:0]    idx;
    logic [1:0]    win;
    logic          found;

    // during a packet the current owner is masked so it cannot win twice in a row
    always_comb begin
        cand = (state == PACKET) ? bus.req & ~bus.grant : bus.req;
`ifdef DATA_ISLAND_PRIORITY_SRC0_EN
        rr_set = cand & 4'b1110;
`else
        rr_set = cand;
`endif
        found = 1'b0;
        win = 2'd0;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && rr_set[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
`ifdef DATA_ISLAND_PRIORITY_SRC0_EN
        if (cand[0]) begin
            found = 1'b1;
            win = 2'd0;
        end
`endif
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            npk <= '0;
            ptr <= 2'd0;
            bus.grant <= 4'b0;
            bus.source_sel <= 2'd0;
            bus.null_packet <= 1'b0;
            bus.packet_start <= 1'b0;
            bus.preamble <= 1'b0;
            bus.guard <= 1'b0;
            bus.data_island_period <= 1'b0;
        end else begin
            bus.packet_start <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    npk <= '0;
                    if (|bus.req && {1'b0, bus.blank_remaining} >= ENTER_MIN) begin
                        state <= PREAMBLE;
                        bus.preamble <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(7)) begin
                        cnt <= '0;
                        state <= GUARD_LEAD;
                        bus.preamble <= 1'b0;
                        bus.guard <= 1'b1;
                    end
                end
                GUARD_LEAD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(1)) begin
                        cnt <= '0;
                        state <= PACKET;
                        bus.guard <= 1'b0;
                        bus.data_island_period <= 1'b1;
                        bus.packet_start <= 1'b1;
                        npk <= (npk == PW'(MAX_PACKETS)) ? npk : npk + 1'b1;
                        bus.grant <= found ? 4'b1 << win : 4'b0;
                        bus.source_sel <= found ? win : 2'd0;
                        bus.null_packet <= !found;
                        if (found) ptr <= win + 2'd1;
                    end
                end
                PACKET: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(31)) begin
                        cnt <= '0;
                        if (found && npk < PW'(MAX_PACKETS) && {1'b0, bus.blank_remaining} >= CONT_MIN) begin
                            bus.packet_start <= 1'b1;
                            npk <= npk + 1'b1;
                            bus.grant <= 4'b1 << win;
                            bus.source_sel <= win;
                            bus.null_packet <= 1'b0;
                            ptr <= win + 2'd1;
                        end else begin
                            state <= GUARD_TRAIL;
                            bus.guard <= 1'b1;
                            bus.data_island_period <= 1'b0;
                            bus.grant <= 4'b0;
                            bus.source_sel <= 2'd0;
                            bus.null_packet <= 1'b0;
                        end
                    end
                end
                GUARD_TRAIL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(1)) begin
                        cnt <= '0;
                        state <= COOLDOWN;
                        bus.guard <= 1'b0;
                    end
                end
                COOLDOWN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MIN_CONTROL - 1)) begin
                        cnt <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_island_scheduler.sv
// tb_data_island_scheduler: scoreboard bench; expected {null_packet, grant} per packet queued with the stimulus.
module tb_data_island_scheduler;
    logic clk_pixel = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    data_island_scheduler_if bus();

    data_island_scheduler dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic sig(input int sel);
        return sel == 0 ? bus.preamble : sel == 1 ? bus.guard : bus.data_island_period;
    endfunction

    function automatic logic [31:0] all_out();
        return {bus.grant, bus.source_sel, bus.null_packet, bus.packet_start, bus.preamble, bus.guard, bus.data_island_period};
    endfunction

    task automatic wait_high(input int sel, output int t);
        t = 0;
        while (!sig(sel) && t < 300) begin
            @(negedge clk_pixel);
            t++;
        end
        check("wait_timeout", 32'(t < 300), 1);
    endtask

    task automatic span(input int sel, output int n);
        n = 0;
        while (sig(sel) && n < 1000) begin
            n++;
            @(negedge clk_pixel);
        end
    endtask

    task automatic do_reset();
        bus.req = 4'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk_pixel);
        check("rst_outputs", all_out(), 0);
        reset = 1'b0;
    endtask

    // packet-level scoreboard plus per-cycle invariants
    int pc = 0;
    logic [3:0] last_grant;
    always @(negedge clk_pixel) begin
        logic [4:0] e;
        if (reset) begin
            pc = 0;
        end else begin
            check("phase_excl", 32'($countones({bus.preamble, bus.guard, bus.data_island_period}) <= 1), 1);
            if (bus.data_island_period) begin
                check("pstart_pos", 32'(bus.packet_start), 32'(pc % 32 == 0));
                if (pc % 32 != 0) check("grant_hold", 32'(bus.grant), 32'(last_grant));
                if (bus.packet_start) begin
                    e = exp_q.size() != 0 ? exp_q.pop_front() : 5'h1f;
                    check("pkt_grant", {bus.null_packet, bus.grant}, 32'(e));
                    check("pkt_sel", 32'(bus.source_sel), 32'(enc(e[3:0])));
                end
                last_grant = bus.grant;
                pc++;
            end else begin
                pc = 0;
                check("idle_grant", {bus.grant, bus.null_packet, bus.packet_start}, 0);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, t, g, k;
        bus.req = 4'b0;
        bus.blank_remaining = 12'd0;
        @(negedge clk_pixel);

        // single source: phase lengths and cooldown gap to the next island
        do_reset();
        exp_q.push_back(5'h01);
        exp_q.push_back(5'h01);
        bus.blank_remaining = 12'd200;
        bus.req = 4'b0001;
        wait_high(0, t);
        span(0, n); check("pre_len", n, 8);
        span(1, n); check("lead_len", n, 2);
        span(2, n); check("pkt_len", n, 32);
        span(1, n); check("trail_len", n, 2);
        g = 0;
        while (!bus.preamble && g < 100) begin
            g++;
            @(negedge clk_pixel);
        end
        check("cool_gap", g, 13);
        wait_high(2, t);
        span(2, n);
        bus.req = 4'b0;
        repeat (20) @(negedge clk_pixel);

        // all sources: round robin, 18-packet cap, order continues into next island
        do_reset();
        for (k = 0; k < 36; k++) exp_q.push_back(5'(4'b1 << (k % 4)));
        bus.blank_remaining = 12'd2000;
        bus.req = 4'b1111;
        wait_high(2, t);
        span(2, n); check("island1_len", n, 576);
        wait_high(2, t);
        span(2, n); check("island2_len", n, 576);
        bus.req = 4'b0;
        repeat (20) @(negedge clk_pixel);

        // entry threshold 55 vs 56
        do_reset();
        bus.req = 4'b0010;
        bus.blank_remaining = 12'd55;
        g = 0;
        repeat (20) begin
            @(negedge clk_pixel);
            g += int'(bus.preamble);
        end
        check("no_enter_55", g, 0);
        exp_q.push_back(5'h02);
        bus.blank_remaining = 12'd56;
        wait_high(0, t);
        check("enter_lat_56", t, 1);
        wait_high(2, t);
        bus.req = 4'b0;
        span(2, n); check("pkt_len_56", n, 32);
        repeat (20) @(negedge clk_pixel);

        // one-cycle request gives a single null packet
        do_reset();
        exp_q.push_back(5'h10);
        bus.blank_remaining = 12'd200;
        bus.req = 4'b0001;
        @(negedge clk_pixel);
        bus.req = 4'b0;
        wait_high(2, t);
        g = 0;
        repeat (32) begin
            g += int'(bus.null_packet && bus.grant == 4'b0);
            @(negedge clk_pixel);
        end
        check("null_cycles", g, 32);
        check("null_single", 32'(bus.data_island_period), 0);
        repeat (20) @(negedge clk_pixel);

        // reset on packet cycle 10 aborts and clears the round-robin pointer
        do_reset();
        exp_q.push_back(5'h04);
        bus.blank_remaining = 12'd200;
        bus.req = 4'b0100;
        wait_high(2, t);
        bus.req = 4'b0;
        repeat (10) @(negedge clk_pixel);
        reset = 1'b1;
        @(negedge clk_pixel);
        check("abort_outputs", all_out(), 0);
        reset = 1'b0;
        exp_q.push_back(5'h04);
        bus.req = 4'b1100;
        wait_high(0, t);
        check("restart_lat", t, 1);
        wait_high(2, t);
        bus.req = 4'b0;
        span(2, n); check("restart_len", n, 32);
        repeat (20) @(negedge clk_pixel);

        // source 0 requests mid-packet while sources 1-3 are pending
        do_reset();
        exp_q.push_back(5'h02);
        bus.blank_remaining = 12'd200;
        bus.req = 4'b1110;
        wait_high(2, t);
        repeat (5) @(negedge clk_pixel);
        bus.req = 4'b1111;
`ifdef DATA_ISLAND_PRIORITY_SRC0_EN
        exp_q.push_back(5'h01);
`else
        exp_q.push_back(5'h04);
`endif
        repeat (27) @(negedge clk_pixel);
        bus.req = 4'b0;
        check("second_pkt", 32'(bus.packet_start), 1);
        span(2, n); check("second_len", n, 32);
        repeat (20) @(negedge clk_pixel);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
